// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer.
// Decodes the EX/MEM access and runs a req/ready transfer on the data bus.
// The pipeline is stalled until the access completes. Load data is extracted
// from the addressed byte lane and sign- or zero-extended.
// Misaligned or illegal accesses fault without touching the bus.
// A bus that never answers faults after TIMEOUT request cycles.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ex_mem_mem_read,
  input  logic              ex_mem_mem_write,
  input  logic [ADDR_W-1:0] ex_mem_alu_result,
  input  logic [31:0]       ex_mem_mem_write_data,
  input  logic [2:0]        ex_mem_funct3,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [31:0]       mem_load_data,
  output logic              mem_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [1:0]        addr_lo_reg;
  logic [2:0]        funct3_reg;
  logic              bus_req_reg;
  logic              bus_we_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [31:0]       bus_wdata_reg;
  logic [3:0]        bus_be_reg;
  logic              done_reg;
  logic              fault_reg;
  logic [31:0]       load_data_reg;

  logic        op;
  logic        is_store;
  logic [1:0]  size;
  logic        access_fault;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [15:0] ld_lo;
  logic [31:0] ld_fmt;

  // A read wins when both read and write are flagged.
  assign op       = ex_mem_mem_read | ex_mem_mem_write;
  assign is_store = ex_mem_mem_write & ~ex_mem_mem_read;
  assign size     = ex_mem_funct3[1:0];

  // Legality: unknown size codes, unsigned stores, and misaligned halves/words.
  always_comb begin
    access_fault = 1'b0;
    if (ex_mem_funct3 == 3'd3 || ex_mem_funct3 == 3'd6 || ex_mem_funct3 == 3'd7)
      access_fault = 1'b1;
    if (is_store && ex_mem_funct3[2])
      access_fault = 1'b1;
    if (size == 2'd1 && ex_mem_alu_result[0])
      access_fault = 1'b1;
    if (size == 2'd2 && ex_mem_alu_result[1:0] != 2'b00)
      access_fault = 1'b1;
  end

  // Store byte enables select the addressed lane(s).
  always_comb begin
    case (size)
      2'd0:    st_be = 4'b0001 << ex_mem_alu_result[1:0];
      2'd1:    st_be = 4'b0011 << {ex_mem_alu_result[1], 1'b0};
      default: st_be = 4'b1111;
    endcase
  end

  // Store data is replicated across every lane so the enabled lane carries it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_wdata[8*gi +: 8] = (size == 2'd0) ? ex_mem_mem_write_data[7:0] :
                                 (size == 2'd1) ? ex_mem_mem_write_data[8*(gi%2) +: 8] :
                                                  ex_mem_mem_write_data[8*gi +: 8];
  end

  assign ld_lo = 16'(bus_rdata >> {addr_lo_reg, 3'b000});

  // Load formatting from the captured size/sign code.
  always_comb begin
    case (funct3_reg)
      3'd0:    ld_fmt = {{24{ld_lo[7]}}, ld_lo[7:0]};
      3'd1:    ld_fmt = {{16{ld_lo[15]}}, ld_lo[15:0]};
      3'd4:    ld_fmt = {24'd0, ld_lo[7:0]};
      3'd5:    ld_fmt = {16'd0, ld_lo[15:0]};
      default: ld_fmt = bus_rdata;
    endcase
  end

  // Stall while an op waits in IDLE or the bus transfer is in flight.
  always_comb begin
    case (state_reg)
      ST_IDLE: mem_stall = op;
      ST_REQ:  mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Access sequencer with registered bus and result outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      addr_lo_reg   <= 2'b00;
      funct3_reg    <= 3'd0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= 32'd0;
      bus_be_reg    <= 4'd0;
      done_reg      <= 1'b0;
      fault_reg     <= 1'b0;
      load_data_reg <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (op) begin
            addr_lo_reg   <= ex_mem_alu_result[1:0];
            funct3_reg    <= ex_mem_funct3;
            bus_we_reg    <= is_store;
            bus_addr_reg  <= {ex_mem_alu_result[ADDR_W-1:2], 2'b00};
            bus_wdata_reg <= st_wdata;
            bus_be_reg    <= is_store ? st_be : 4'b0000;
            if (access_fault) begin
              // Rejected without a bus cycle; report on the next cycle.
              state_reg     <= ST_DONE;
              done_reg      <= 1'b1;
              fault_reg     <= 1'b1;
              load_data_reg <= 32'd0;
            end else begin
              state_reg   <= ST_REQ;
              bus_req_reg <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (bus_ready) begin
            bus_req_reg   <= 1'b0;
            load_data_reg <= bus_we_reg ? 32'd0 : ld_fmt;
            done_reg      <= 1'b1;
            fault_reg     <= 1'b0;
            state_reg     <= ST_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            bus_req_reg   <= 1'b0;
            load_data_reg <= 32'd0;
            done_reg      <= 1'b1;
            fault_reg     <= 1'b1;
            state_reg     <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          // EX/MEM still holds the finished instruction here, so ignore op.
          done_reg      <= 1'b0;
          fault_reg     <= 1'b0;
          load_data_reg <= 32'd0;
          cnt_reg       <= '0;
          state_reg     <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem_done      = done_reg;
  assign mem_fault     = fault_reg;
  assign mem_load_data = load_data_reg;
  assign bus_req       = bus_req_reg;
  assign bus_we        = bus_we_reg;
  assign bus_addr      = bus_addr_reg;
  assign bus_wdata     = bus_wdata_reg;
  assign bus_be        = bus_be_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed and random loads/stores checked
// against a reference model built from the access rules.
module tb_mem_access_ctrl;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              ex_mem_mem_read;
  logic              ex_mem_mem_write;
  logic [ADDR_W-1:0] ex_mem_alu_result;
  logic [31:0]       ex_mem_mem_write_data;
  logic [2:0]        ex_mem_funct3;
  logic              mem_stall;
  logic              mem_done;
  logic [31:0]       mem_load_data;
  logic              mem_fault;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ready;
  logic [31:0]       bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .ex_mem_mem_read       (ex_mem_mem_read),
    .ex_mem_mem_write      (ex_mem_mem_write),
    .ex_mem_alu_result     (ex_mem_alu_result),
    .ex_mem_mem_write_data (ex_mem_mem_write_data),
    .ex_mem_funct3         (ex_mem_funct3),
    .mem_stall             (mem_stall),
    .mem_done              (mem_done),
    .mem_load_data         (mem_load_data),
    .mem_fault             (mem_fault),
    .bus_req               (bus_req),
    .bus_we                (bus_we),
    .bus_addr              (bus_addr),
    .bus_wdata             (bus_wdata),
    .bus_be                (bus_be),
    .bus_ready             (bus_ready),
    .bus_rdata             (bus_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit ref_legal(bit rd, bit wr, logic [2:0] f3, logic [31:0] addr);
    bit st;
    st = wr && !rd;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 0;
    if (st && (f3 == 4 || f3 == 5)) return 0;
    if ((f3 == 1 || f3 == 5) && (addr % 2) != 0) return 0;
    if (f3 == 2 && (addr % 4) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
    logic [31:0] sh, b, h;
    sh = rdata >> (8 * (addr % 4));
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? (b + 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32768) ? (h + 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(logic [2:0] f3, logic [31:0] addr);
    int k;
    k = addr % 4;
    case (f3)
      3'd0:    return 4'(1 << k);
      3'd1:    return 4'(3 << ((k / 2) * 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] d);
    case (f3)
      3'd0:    return (d % 256) * 32'h01010101;
      3'd1:    return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // Runs one access from the current IDLE cycle to the IDLE cycle after done.
  // delay = REQ cycles without ready before ready; delay >= TIMEOUT means never.
  task automatic run_op(input string name, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] d,
                        input logic [2:0] f3, input int delay, input logic [31:0] rdata);
    bit legal, st, exp_fault;
    int exp_req, exp_done, reqcnt, done_cyc;
    logic [31:0] exp_load;
    legal     = ref_legal(rd, wr, f3, addr);
    st        = wr && !rd;
    exp_fault = !legal || (delay >= TIMEOUT);
    exp_req   = !legal ? 0 : ((delay < TIMEOUT) ? delay + 1 : TIMEOUT);
    exp_done  = 1 + exp_req;
    exp_load  = (legal && !st && delay < TIMEOUT) ? ref_load(f3, addr, rdata) : 32'd0;

    ex_mem_mem_read       = rd;
    ex_mem_mem_write      = wr;
    ex_mem_alu_result     = addr;
    ex_mem_mem_write_data = d;
    ex_mem_funct3         = f3;
    #1;
    n_checks++;
    if (mem_stall !== 1'b1) begin
      n_fail++; $display("FAIL %s/stall_c0: got %b expected 1", name, mem_stall);
    end
    n_checks++;
    if (mem_done !== 1'b0) begin
      n_fail++; $display("FAIL %s/done_c0: got %b expected 0", name, mem_done);
    end
    @(posedge clk); #1;

    reqcnt   = 0;
    done_cyc = -1;
    for (int c = 1; c <= TIMEOUT + 4; c++) begin
      bus_ready = 1'b0;
      if (mem_done === 1'b1) begin
        done_cyc = c;
        n_checks++;
        if (mem_fault !== exp_fault) begin
          n_fail++; $display("FAIL %s/fault: got %b expected %b", name, mem_fault, exp_fault);
        end
        n_checks++;
        if (mem_load_data !== exp_load) begin
          n_fail++; $display("FAIL %s/load_data: got %h expected %h", name, mem_load_data, exp_load);
        end
        n_checks++;
        if (mem_stall !== 1'b0 || bus_req !== 1'b0) begin
          n_fail++; $display("FAIL %s/done_quiet: got stall=%b req=%b expected 0 0", name, mem_stall, bus_req);
        end
        break;
      end
      n_checks++;
      if (mem_stall !== 1'b1) begin
        n_fail++; $display("FAIL %s/stall_busy: cycle %0d got %b expected 1", name, c, mem_stall);
      end
      if (bus_req === 1'b1) begin
        n_checks++;
        if (bus_addr !== {addr[31:2], 2'b00} || bus_we !== st) begin
          n_fail++; $display("FAIL %s/bus_addr_we: got %h/%b expected %h/%b", name, bus_addr, bus_we, {addr[31:2], 2'b00}, st);
        end
        n_checks++;
        if (bus_be !== (st ? ref_be(f3, addr) : 4'b0000)) begin
          n_fail++; $display("FAIL %s/bus_be: got %b expected %b", name, bus_be, st ? ref_be(f3, addr) : 4'b0000);
        end
        if (st) begin
          n_checks++;
          if (bus_wdata !== ref_wdata(f3, d)) begin
            n_fail++; $display("FAIL %s/bus_wdata: got %h expected %h", name, bus_wdata, ref_wdata(f3, d));
          end
        end
        if (reqcnt == delay) begin
          bus_ready = 1'b1;
          bus_rdata = rdata;
        end else begin
          bus_rdata = $urandom;
        end
        reqcnt++;
      end
      @(posedge clk); #1;
    end
    bus_ready = 1'b0;

    n_checks++;
    if (done_cyc != exp_done) begin
      n_fail++; $display("FAIL %s/done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
    end
    n_checks++;
    if (reqcnt != exp_req) begin
      n_fail++; $display("FAIL %s/req_cycles: got %0d expected %0d", name, reqcnt, exp_req);
    end
    $display("op %-10s rd=%b wr=%b addr=%h f3=%0d delay=%0d done_cyc=%0d req=%0d fault=%b load=%h",
             name, rd, wr, addr, f3, delay, done_cyc, reqcnt, mem_fault, mem_load_data);

    // Move into the following IDLE cycle; results must have cleared.
    @(posedge clk); #1;
    ex_mem_mem_read  = 1'b0;
    ex_mem_mem_write = 1'b0;
    n_checks++;
    if (mem_done !== 1'b0 || mem_fault !== 1'b0 || mem_load_data !== 32'd0) begin
      n_fail++; $display("FAIL %s/after_done: got done=%b fault=%b load=%h expected 0 0 0", name, mem_done, mem_fault, mem_load_data);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    ex_mem_mem_read = 0; ex_mem_mem_write = 0; ex_mem_alu_result = 0;
    ex_mem_mem_write_data = 0; ex_mem_funct3 = 0; bus_ready = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_stall, mem_done, mem_fault, bus_req, bus_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset/flags: got %b expected 00000", {mem_stall, mem_done, mem_fault, bus_req, bus_we});
    end
    n_checks++;
    if (bus_addr !== '0 || bus_wdata !== 32'd0 || bus_be !== 4'd0 || mem_load_data !== 32'd0) begin
      n_fail++; $display("FAIL reset/data: got %h %h %b %h expected zeros", bus_addr, bus_wdata, bus_be, mem_load_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op("lw_100",    1, 0, 32'h100, 32'h0,        3'd2, 2, 32'hDEADBEEF);
    run_op("sb_103",    0, 1, 32'h103, 32'h000000A5, 3'd0, 0, 32'h0);
    run_op("lb_102",    1, 0, 32'h102, 32'h0,        3'd0, 1, 32'h00800000);
    run_op("lhu_102",   1, 0, 32'h102, 32'h0,        3'd5, 0, 32'h80010000);
    run_op("sh_102",    0, 1, 32'h102, 32'h1234BEEF, 3'd1, 3, 32'h0);
    run_op("sw_200",    0, 1, 32'h200, 32'hCAFEF00D, 3'd2, 0, 32'h0);
  endtask

  task automatic test_faults();
    run_op("lw_mis",    1, 0, 32'h102, 32'h0, 3'd2, 0, 32'h11111111);
    run_op("ld_f3_3",   1, 0, 32'h100, 32'h0, 3'd3, 0, 32'h11111111);
    run_op("lh_mis",    1, 0, 32'h101, 32'h0, 3'd1, 0, 32'h11111111);
    run_op("sbu_store", 0, 1, 32'h100, 32'h5, 3'd4, 0, 32'h0);
    run_op("timeout",   1, 0, 32'h104, 32'h0, 3'd2, TIMEOUT + 10, 32'h0);
  endtask

  task automatic test_read_write_both();
    run_op("rd_wr",     1, 1, 32'h301, 32'hFFFFFFFF, 3'd4, 1, 32'h0000F700);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_0", 1, 0, 32'h10, 32'h0,  3'd2, 0, 32'h01234567);
    run_op("b2b_1", 0, 1, 32'h12, 32'h9A, 3'd0, 0, 32'h0);
    run_op("b2b_2", 1, 0, 32'h12, 32'h0,  3'd1, 0, 32'h8F00AAAA);
  endtask

  task automatic test_reset_mid_req();
    ex_mem_mem_read = 1; ex_mem_mem_write = 0; ex_mem_alu_result = 32'h400;
    ex_mem_funct3 = 3'd2; bus_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset/req_before: got %b expected 1", bus_req);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset/req_drop: got %b expected 0", bus_req);
    end
    ex_mem_mem_read = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus_req !== 1'b0 || mem_done !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset/no_resume: got req=%b done=%b stall=%b expected 0 0 0", bus_req, mem_done, mem_stall);
    end
    run_op("lw_after", 1, 0, 32'h400, 32'h0, 3'd2, 1, 32'h5A5A1234);
  endtask

  task automatic test_random();
    logic [2:0] f3_tab [8];
    logic [31:0] addr;
    int sel;
    bit rd, wr;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      rd  = (sel <= 2) || (sel == 5);
      wr  = (sel == 3) || (sel == 4) || (sel == 5);
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      sel = $urandom_range(0, 9);
      run_op($sformatf("rnd_%0d", i), rd, wr, addr, $urandom,
             f3_tab[(sel >= 8) ? sel - 8 : sel], $urandom_range(0, 5), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_faults();
    test_read_write_both();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
